// File: rtl/imem_dmem_arbiter_if.sv
// Bundle of the fetch, data and memory-side signals around the imem/dmem arbiter.
// The slave modport is the arbiter's view. The master modport is the view of the core plus memory.
interface imem_dmem_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                    if_req;
  logic [ADDR_WIDTH-1:0]   if_addr;
  logic                    if_flush;
  logic                    if_gnt;
  logic                    if_rvalid;
  logic [DATA_WIDTH-1:0]   if_rdata;

  logic                    d_req;
  logic                    d_we;
  logic [ADDR_WIDTH-1:0]   d_addr;
  logic [DATA_WIDTH-1:0]   d_wdata;
  logic [DATA_WIDTH/8-1:0] d_be;
  logic                    d_gnt;
  logic                    d_rvalid;
  logic [DATA_WIDTH-1:0]   d_rdata;

  logic                    mem_req;
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [DATA_WIDTH/8-1:0] mem_be;
  logic [DATA_WIDTH-1:0]   mem_rdata;

  modport slave (
    input  if_req, if_addr, if_flush, d_req, d_we, d_addr, d_wdata, d_be, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );

  modport master (
    output if_req, if_addr, if_flush, d_req, d_we, d_addr, d_wdata, d_be, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/imem_dmem_arbiter.sv
// Single-port memory arbiter: combinational same-cycle grant with data priority, and 1-cycle read responses routed by owner.
// Optional fetch starvation guard is enabled by defining IMEM_STARVE_GUARD_EN.
module imem_dmem_arbiter #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int MAX_IF_WAIT = 4
) (
  input  logic                 clk,
  input  logic                 arst_n,
  imem_dmem_arbiter_if.slave   bus
);

  localparam logic [1:0] RESP_NONE = 2'd0;
  localparam logic [1:0] RESP_IF   = 2'd1;
  localparam logic [1:0] RESP_D    = 2'd2;

  logic [1:0] r_resp;
  logic       w_force_if;
  logic       w_if_gnt;
  logic       w_d_gnt;

`ifdef IMEM_STARVE_GUARD_EN
  localparam int                WAIT_W   = $clog2(MAX_IF_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_IF_WAIT);

  logic [WAIT_W-1:0] r_wait;

  assign w_force_if = bus.if_req && (r_wait == WAIT_MAX);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_wait <= '0;
    end else if (!bus.if_req || w_if_gnt) begin
      r_wait <= '0;
    end else if (r_wait != WAIT_MAX) begin
      r_wait <= r_wait + 1'b1;
    end
  end
`else
  assign w_force_if = 1'b0;
`endif

  // Grants are gated by arst_n so nothing reaches memory while reset is held.
  assign w_d_gnt  = arst_n & bus.d_req & ~w_force_if;
  assign w_if_gnt = arst_n & bus.if_req & ~w_d_gnt;

  assign bus.d_gnt  = w_d_gnt;
  assign bus.if_gnt = w_if_gnt;

  always_comb begin
    bus.mem_req   = w_d_gnt | w_if_gnt;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_be    = '0;
    if (w_d_gnt) begin
      bus.mem_we    = bus.d_we;
      bus.mem_addr  = bus.d_addr;
      bus.mem_wdata = bus.d_wdata;
      bus.mem_be    = bus.d_be;
    end else if (w_if_gnt) begin
      bus.mem_addr  = bus.if_addr;
      bus.mem_be    = '1;
    end
  end

  // Stores never return data, so they leave the owner register empty.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_resp <= RESP_NONE;
    end else if (w_d_gnt) begin
      r_resp <= bus.d_we ? RESP_NONE : RESP_D;
    end else if (w_if_gnt) begin
      r_resp <= RESP_IF;
    end else begin
      r_resp <= RESP_NONE;
    end
  end

  logic w_if_rvalid;
  logic w_d_rvalid;

  assign w_if_rvalid   = (r_resp == RESP_IF) && !bus.if_flush;
  assign w_d_rvalid    = (r_resp == RESP_D);

  assign bus.if_rvalid = w_if_rvalid;
  assign bus.if_rdata  = w_if_rvalid ? bus.mem_rdata : '0;
  assign bus.d_rvalid  = w_d_rvalid;
  assign bus.d_rdata   = w_d_rvalid ? bus.mem_rdata : '0;

endmodule
